spi_txn_controller: RTL
=======================

Name: spi_txn_controller

Overview:
Sequences multi-byte SPI mode-0 transactions on top of clock_divider. Programs the divider, issues one 8-SCLK burst per byte and frames each transaction with chip select. Serialises MOSI and deserialises MISO from the divider's o_clk edges, with a byte-level valid/ready interface toward the host logic.

Parameters:
LEN_W, 4, width of byte-count field; 1..2^LEN_W-1 bytes per transaction
CS_SETUP, 2, i_clk cycles from o_cs_n falling to first divider start
CS_HOLD, 2, i_clk cycles from last burst idle to o_cs_n rising

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_req  in  1  transaction request, sampled in IDLE only
i_divisor  in  8  SCLK divisor (SCLK = i_clk/divisor), valid with i_req
i_len  in  LEN_W  byte count, valid with i_req
o_busy  out  1  high from accepted i_req until DONE exits
o_err  out  1  one-cycle pulse on rejected request
i_tx_data  in  8  next TX byte
o_tx_ready  out  1  one-cycle pulse: i_tx_data captured this cycle
o_rx_data  out  8  last received byte, held until next o_rx_valid
o_rx_valid  out  1  one-cycle pulse per received byte
o_cs_n  out  1  SPI chip select, active low
o_mosi  out  1  SPI MOSI
i_miso  in  1  SPI MISO
o_sclk  out  1  SPI clock, equal to i_div_clk while o_cs_n low, else 0
o_div_config  out  9  to divider i_config: {divisor, load}
o_div_start_n  out  1  to divider i_start_n
i_div_idle  in  1  from divider o_idle
i_div_clk  in  1  from divider o_clk

Behaviour:
- Reset (async, any state): state IDLE, o_busy=0, o_err=0, o_tx_ready=0, o_rx_valid=0, o_rx_data=0, o_cs_n=1, o_mosi=0, o_div_config=0, o_div_start_n=1, cached divisor=0. Divider is assumed reset by the same i_rst_n.
- IDLE: on i_req=1, reject if i_divisor<2 or i_len==0. Rejection pulses o_err for 1 cycle and stays in IDLE. Otherwise latch divisor and length, set o_busy. Go to CONFIG if divisor != cached divisor, else CS_SETUP.
- CONFIG: drive o_div_config={divisor,1}. Wait for i_div_idle to fall, then rise. On the rise, clear o_div_config to 0, update the cache, and go to CS_SETUP.
- CS_SETUP: o_cs_n=0. Pulse o_tx_ready and capture i_tx_data into the shift register in the entry cycle; o_mosi=bit7. After CS_SETUP cycles, go to START.
- START: hold o_div_start_n=0 until i_div_idle=0, then release to 1 and go to SHIFT.
- SHIFT: track the previous value of i_div_clk.
  - Rising edge: sample i_miso into the RX shift register LSB, MSB-first.
  - Falling edge: shift TX left and present the next bit on o_mosi.
  - Exactly 8 rising edges per byte; bit counter saturates at 8.
  - On i_div_idle rising, go to BYTE_END.
- BYTE_END (1 cycle):
  - o_rx_data=RX register; pulse o_rx_valid; decrement remaining.
  - If remaining>0: pulse o_tx_ready, load the next byte, set o_mosi=bit7, go to START. Back-to-back bytes; o_cs_n stays low.
  - Else go to CS_HOLD.
- CS_HOLD: after CS_HOLD cycles, o_cs_n=1 and go to DONE.
- DONE (1 cycle): o_busy=0, return to IDLE. i_req is not sampled in DONE.
- If fewer than 8 rising edges are seen before idle returns, the partial byte is still reported and no error is raised.
- i_req while o_busy is ignored.
- Divisor change across transactions triggers CONFIG; a matching divisor skips it.

Test Plan:
- Reset mid-SHIFT (byte 1 of 3): o_cs_n=1, o_div_start_n=1, o_div_config=0, o_busy=0 immediately; next i_req with the same divisor re-runs CONFIG (cache cleared).
- i_req divisor=4, len=1, tx=0xA5, MISO loopback: one CONFIG, 8 SCLK periods of 40ns. MOSI bits 1,0,1,0,0,1,0,1 stable at each rising edge. o_rx_data=0xA5 with one o_rx_valid. o_cs_n high CS_HOLD cycles after idle.
- divisor=2, len=3, tx 0x01,0x80,0xFF, MISO tied 1: three o_tx_ready pulses, three o_rx_valid with 0xFF, o_cs_n low continuously, 24 SCLK rising edges total.
- Second request divisor=2 right after the previous one: no CONFIG (o_div_config stays 0), o_cs_n falls within 1 cycle of i_req.
- i_req divisor=1 or len=0: o_err one-cycle pulse, o_busy stays 0, no divider activity.
- divisor=250, len=2, i_req re-asserted while busy: ignored; exactly 2 bytes transferred, o_busy falls once.

Source files
------------

// File: rtl/spi_txn_controller.sv
// SPI mode-0 transaction sequencer on top of an external clock divider.
// Frames multi-byte transfers with chip select and moves bytes over a valid/ready style host interface.
module spi_txn_controller #(
  parameter int LEN_W    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic [7:0]       i_divisor,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_err,
  input  logic [7:0]       i_tx_data,
  output logic             o_tx_ready,
  output logic [7:0]       o_rx_data,
  output logic             o_rx_valid,
  output logic             o_cs_n,
  output logic             o_mosi,
  input  logic             i_miso,
  output logic             o_sclk,
  output logic [8:0]       o_div_config,
  output logic             o_div_start_n,
  input  logic             i_div_idle,
  input  logic             i_div_clk
);

  typedef enum logic [2:0] {
    IDLE, CONFIG, CS_SETUP_ST, START, SHIFT, BYTE_END, CS_HOLD_ST, DONE
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             cs_n_q, cs_n_d;
  logic [8:0]       cfg_q, cfg_d;
  logic             start_n_q, start_n_d;
  logic [7:0]       cache_q, cache_d;
  logic [7:0]       div_q, div_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             seen_low_q, seen_low_d;
  logic             prev_clk_q;
  logic             tx_ready;
  logic             sclk_rise, sclk_fall;

  assign sclk_rise = i_div_clk & ~prev_clk_q;
  assign sclk_fall = ~i_div_clk & prev_clk_q;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    cs_n_d     = cs_n_q;
    cfg_d      = cfg_q;
    start_n_d  = start_n_q;
    cache_d    = cache_q;
    div_d      = div_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rem_d      = rem_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    seen_low_d = seen_low_q;
    tx_ready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req) begin
          if (i_divisor < 8'd2 || i_len == '0) begin
            err_d = 1'b1;
          end else begin
            busy_d = 1'b1;
            div_d  = i_divisor;
            rem_d  = i_len;
            cnt_d  = 8'd0;
            if (i_divisor != cache_q) begin
              state_d    = CONFIG;
              cfg_d      = {i_divisor, 1'b1};
              seen_low_d = 1'b0;
            end else begin
              state_d = CS_SETUP_ST;
              cs_n_d  = 1'b0;
            end
          end
        end
      end
      // The divider acknowledges a load by dropping idle and raising it again.
      CONFIG: begin
        if (!i_div_idle) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          cfg_d   = 9'd0;
          cache_d = div_q;
          state_d = CS_SETUP_ST;
          cs_n_d  = 1'b0;
          cnt_d   = 8'd0;
        end
      end
      CS_SETUP_ST: begin
        if (cnt_q == 8'd0) begin
          tx_ready = 1'b1;
          tx_d     = i_tx_data;
        end
        if (cnt_q == 8'(CS_SETUP - 1)) begin
          state_d   = START;
          start_n_d = 1'b0;
          bit_d     = 4'd0;
          rx_d      = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      START: begin
        if (!i_div_idle) begin
          start_n_d = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise && bit_q < 4'd8) begin
          rx_d  = {rx_q[6:0], i_miso};
          bit_d = bit_q + 4'd1;
        end
        if (sclk_fall) begin
          tx_d = {tx_q[6:0], 1'b0};
        end
        if (i_div_idle) begin
          state_d = BYTE_END;
        end
      end
      BYTE_END: begin
        rx_data_d  = rx_q;
        rx_valid_d = 1'b1;
        rem_d      = rem_q - LEN_W'(1);
        if (rem_q > LEN_W'(1)) begin
          tx_ready  = 1'b1;
          tx_d      = i_tx_data;
          state_d   = START;
          start_n_d = 1'b0;
          bit_d     = 4'd0;
          rx_d      = 8'd0;
        end else begin
          state_d = CS_HOLD_ST;
          cnt_d   = 8'd0;
        end
      end
      CS_HOLD_ST: begin
        if (cnt_q == 8'(CS_HOLD - 1)) begin
          cs_n_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
      cs_n_q     <= 1'b1;
      cfg_q      <= 9'd0;
      start_n_q  <= 1'b1;
      cache_q    <= 8'd0;
      div_q      <= 8'd0;
      tx_q       <= 8'd0;
      rx_q       <= 8'd0;
      rem_q      <= '0;
      bit_q      <= 4'd0;
      cnt_q      <= 8'd0;
      seen_low_q <= 1'b0;
      prev_clk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      cs_n_q     <= cs_n_d;
      cfg_q      <= cfg_d;
      start_n_q  <= start_n_d;
      cache_q    <= cache_d;
      div_q      <= div_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rem_q      <= rem_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      seen_low_q <= seen_low_d;
      prev_clk_q <= i_div_clk;
    end
  end

  assign o_busy        = busy_q;
  assign o_err         = err_q;
  assign o_tx_ready    = tx_ready;
  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_cs_n        = cs_n_q;
  assign o_mosi        = tx_q[7];
  assign o_sclk        = i_div_clk & ~cs_n_q;
  assign o_div_config  = cfg_q;
  assign o_div_start_n = start_n_q;

endmodule
